// File: rtl/dadd_arb_pkg.sv
// dadd_arb_pkg: shared constants, operand typedefs and the round-robin
// index helper for the dadd arbiter.
package dadd_arb_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int OSTD_DEPTH_DEF = 4;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  // Wide enough for up to eight requesters.
  typedef logic [2:0] req_idx_t;

  // Returns (base + offset) modulo numReq, for offset < numReq.
  function automatic req_idx_t rrIndex(input req_idx_t base, input int unsigned offset,
                                       input int unsigned numReq);
    int unsigned sum;
    sum = 32'(base) + offset;
    if (sum >= numReq) sum = sum - numReq;
    return req_idx_t'(sum);
  endfunction

endpackage

// File: rtl/dadd_arb_if.sv
// dadd_arb_if: requester handshake, response and dadd datapath signals.
// The slave modport is the arbiter's view; master is the environment's view.
interface dadd_arb_if
  import dadd_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
);

  logic [NUM_REQ-1:0]  req_valid;
  addr_t [NUM_REQ-1:0] req_addr;
  data_t [NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]  req_ready;

  logic  dadd_in_en;
  addr_t dadd_in_addr;
  data_t dadd_in;

  logic  dadd_out_en;
  addr_t dadd_out_addr;
  data_t dadd_out;

  logic [NUM_REQ-1:0] rsp_valid;
  addr_t              rsp_addr;
  data_t              rsp_data;

  modport slave (
    input  req_valid, req_addr, req_data, dadd_out_en, dadd_out_addr, dadd_out,
    output req_ready, dadd_in_en, dadd_in_addr, dadd_in, rsp_valid, rsp_addr, rsp_data
  );

  modport master (
    output req_valid, req_addr, req_data, dadd_out_en, dadd_out_addr, dadd_out,
    input  req_ready, dadd_in_en, dadd_in_addr, dadd_in, rsp_valid, rsp_addr, rsp_data
  );

endinterface

// File: rtl/dadd_arb_own_fifo.sv
// dadd_arb_own_fifo: ordered queue of requester indices that own the
// in-flight dadd operations. Results come back in issue order, so the
// head always names the owner of the next result.
module dadd_arb_own_fifo
  import dadd_arb_pkg::*;
#(
  parameter int DEPTH = OSTD_DEPTH_DEF
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_push,
  input  req_idx_t i_push_idx,
  input  logic     i_pop,
  output req_idx_t o_head,
  output logic     o_empty,
  output logic     o_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  req_idx_t      r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr];

  // Store the owner index at the tail; contents need no reset since the count gates them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_idx;
  end

  // Pointers wrap naturally because DEPTH is a power of two; push+pop keeps the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dadd_arb.sv
// dadd_arb: round-robin arbiter sharing one dadd datapath among NUM_REQ
// requesters, with an owner queue routing in-order results back.
// Optional feature: define DADD_ARB_STATS_EN to add the saturating
// per-requester grant counters on output grant_cnt.
module dadd_arb
  import dadd_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int OSTD_DEPTH = OSTD_DEPTH_DEF
) (
  input  logic clk,
  input  logic reset,
  dadd_arb_if.slave bus,
  output logic err_unexp_rsp
`ifdef DADD_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0] grant_cnt
`endif
);

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  req_idx_t r_ptr;
  logic     r_in_en;
  addr_t    r_in_addr;
  data_t    r_in_data;
  logic [NUM_REQ-1:0] r_rsp_valid;
  addr_t    r_rsp_addr;
  data_t    r_rsp_data;
  logic     r_err;

  logic     w_found;
  req_idx_t w_gnt_idx;
  req_idx_t w_cand;
  logic [NUM_REQ-1:0] w_cand_oh;
  addr_t    w_gnt_addr;
  data_t    w_gnt_data;
  logic     w_full;
  logic     w_empty;
  req_idx_t w_head;
  logic     w_pop;
  logic     w_unexp;

  assign w_pop   = bus.dadd_out_en & ~w_empty;
  assign w_unexp = bus.dadd_out_en & w_empty;

  // Round-robin search from r_ptr; a full queue blocks every grant this cycle.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    w_cand_oh = '0;
    if (!w_full) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_cand    = rrIndex(r_ptr, k, NUM_REQ);
        w_cand_oh = ONE_HOT0 << w_cand;
        if (!w_found && |(bus.req_valid & w_cand_oh)) begin
          w_found   = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
    end
  end

  assign bus.req_ready = w_found ? (ONE_HOT0 << w_gnt_idx) : '0;

  // Select the granted requester's operand for the issue register.
  always_comb begin
    w_gnt_addr = '0;
    w_gnt_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt_idx == req_idx_t'(k)) begin
        w_gnt_addr = bus.req_addr[k];
        w_gnt_data = bus.req_data[k];
      end
    end
  end

  // Next search starts just after the requester that won this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= rrIndex(w_gnt_idx, 1, NUM_REQ);
    end
  end

  // Registered issue: strobe for one cycle, operand holds its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_en   <= 1'b0;
      r_in_addr <= '0;
      r_in_data <= '0;
    end else begin
      r_in_en <= w_found;
      if (w_found) begin
        r_in_addr <= w_gnt_addr;
        r_in_data <= w_gnt_data;
      end
    end
  end

  // Route each result to the queue head's owner one cycle after it arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= '0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_pop ? (ONE_HOT0 << w_head) : '0;
      if (w_pop) begin
        r_rsp_addr <= bus.dadd_out_addr;
        r_rsp_data <= bus.dadd_out;
      end
    end
  end

  // A result with nothing outstanding is dropped and flagged until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_unexp) begin
      r_err <= 1'b1;
    end
  end

  dadd_arb_own_fifo #(
    .DEPTH (OSTD_DEPTH)
  ) u_own_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_found),
    .i_push_idx (w_gnt_idx),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  assign bus.dadd_in_en   = r_in_en;
  assign bus.dadd_in_addr = r_in_addr;
  assign bus.dadd_in      = r_in_data;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_addr     = r_rsp_addr;
  assign bus.rsp_data     = r_rsp_data;
  assign err_unexp_rsp    = r_err;

`ifdef DADD_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_grant_cnt;

  // Per-requester transfer counters that stick at 0xFFFF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w_found && (w_gnt_idx == req_idx_t'(k)) && (r_grant_cnt[k] != 16'hFFFF)) begin
          r_grant_cnt[k] <= r_grant_cnt[k] + 16'd1;
        end
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_dadd_arb.sv
// tb_dadd_arb: scoreboard bench for dadd_arb. A reference model predicts
// grants and responses; a behavioural datapath returns in-order results.
module tb_dadd_arb;
  import dadd_arb_pkg::*;

  localparam int NR    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic errUnexp;
`ifdef DADD_ARB_STATS_EN
  logic [NR-1:0][15:0] grantCnt;
`endif

  always #5 clk = ~clk;

  dadd_arb_if #(.NUM_REQ(NR)) bus ();

  dadd_arb #(
    .NUM_REQ    (NR),
    .OSTD_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .err_unexp_rsp (errUnexp)
`ifdef DADD_ARB_STATS_EN
    ,
    .grant_cnt     (grantCnt)
`endif
  );

  int checkCount = 0;
  int errorCount = 0;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic data_t dpFunc(input data_t d);
    return d + 32'h1111_0001;
  endfunction

  typedef struct {
    int    owner;
    addr_t addr;
    data_t data;
  } item_t;

  typedef struct {
    addr_t addr;
    data_t data;
    int    due;
  } dp_t;

  // Reference model state, written only by the monitor.
  item_t ownerQ[$];
  int    mPtr;
  bit    expRspPend;
  item_t expRsp;
  bit    issPend;
  item_t expIss;
  bit    expErr;
  bit [NR-1:0] lastXfer;
  int    grantsSeen = 0;

  // Datapath model state.
  dp_t   dpQ[$];
  int    cyc = 0;
  int    dpLat = 3;
  bit    dpStall = 1'b0;
  int    injectReqCnt = 0;
  int    injectDoneCnt = 0;
  data_t injectData = 32'h0;
  bit    monEnable = 1'b0;
  int    reqSeq = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath: returns each issue dpLat cycles later, in order.
  always @(posedge clk) begin
    #1;
    bus.dadd_out_en = 1'b0;
    if (injectReqCnt > injectDoneCnt) begin
      bus.dadd_out_en   = 1'b1;
      bus.dadd_out_addr = 32'h0;
      bus.dadd_out      = injectData;
      injectDoneCnt++;
    end else if (!dpStall && dpQ.size() > 0 && dpQ[0].due <= cyc) begin
      dp_t e;
      e = dpQ.pop_front();
      bus.dadd_out_en   = 1'b1;
      bus.dadd_out_addr = e.addr;
      bus.dadd_out      = dpFunc(e.data);
    end
  end

  // Monitor and reference model, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    int    expGnt;
    int    idx;
    item_t it;
    if (reset) begin
      ownerQ.delete();
      mPtr       = 0;
      expRspPend = 1'b0;
      issPend    = 1'b0;
      expErr     = 1'b0;
      lastXfer   = '0;
    end else begin
      lastXfer   = bus.req_valid & bus.req_ready;
      grantsSeen += $countones(lastXfer);
      if (bus.dadd_in_en) dpQ.push_back('{bus.dadd_in_addr, bus.dadd_in, cyc + dpLat});
      if (monEnable) begin
        if (expRspPend) begin
          checkOutput("rsp_valid", bus.rsp_valid, 64'd1 << expRsp.owner);
          checkOutput("rsp_addr", bus.rsp_addr, expRsp.addr);
          checkOutput("rsp_data", bus.rsp_data, expRsp.data);
        end else begin
          checkOutput("rsp_idle", bus.rsp_valid, 0);
        end
        checkOutput("err_unexp", errUnexp, expErr);
        if (issPend) begin
          checkOutput("issue_en", bus.dadd_in_en, 1);
          checkOutput("issue_addr", bus.dadd_in_addr, expIss.addr);
          checkOutput("issue_data", bus.dadd_in, expIss.data);
        end else begin
          checkOutput("issue_idle", bus.dadd_in_en, 0);
        end
        expGnt = -1;
        if (ownerQ.size() < DEPTH) begin
          for (int k = 0; k < NR; k++) begin
            idx = (mPtr + k) % NR;
            if (expGnt < 0 && bus.req_valid[idx]) expGnt = idx;
          end
        end
        checkOutput("req_ready", bus.req_ready, (expGnt >= 0) ? (64'd1 << expGnt) : 64'd0);
        expRspPend = 1'b0;
        if (bus.dadd_out_en) begin
          if (ownerQ.size() > 0) begin
            it = ownerQ.pop_front();
            expRsp = '{it.owner, it.addr, dpFunc(it.data)};
            expRspPend = 1'b1;
          end else begin
            expErr = 1'b1;
          end
        end
        issPend = 1'b0;
        if (expGnt >= 0) begin
          it = '{expGnt, bus.req_addr[expGnt], bus.req_data[expGnt]};
          ownerQ.push_back(it);
          expIss  = it;
          issPend = 1'b1;
          mPtr    = (expGnt + 1) % NR;
        end
      end
    end
  end

  // Drive requester valids for a number of cycles; new operands after each transfer.
  task automatic applyStimulus(input logic [NR-1:0] want, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (lastXfer[i] || !bus.req_valid[i]) begin
          reqSeq++;
          bus.req_addr[i] = {8'(i), 24'(reqSeq)};
          bus.req_data[i] = $urandom;
        end
      end
      bus.req_valid = want;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, bus.req_ready, 0);
    checkOutput({tag, "_in_en"}, bus.dadd_in_en, 0);
    checkOutput({tag, "_in_addr"}, bus.dadd_in_addr, 0);
    checkOutput({tag, "_in_data"}, bus.dadd_in, 0);
    checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    checkOutput({tag, "_rsp_addr"}, bus.rsp_addr, 0);
    checkOutput({tag, "_rsp_data"}, bus.rsp_data, 0);
    checkOutput({tag, "_err"}, errUnexp, 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("rst");
    @(posedge clk);
    #1;
    reset     = 1'b0;
    monEnable = 1'b1;

    $display("[TB] alternating requesters 0 and 2, latency 3");
    dpLat = 3;
    applyStimulus(4'b0101, 16);
    applyStimulus(4'b0000, 10);

    $display("[TB] all requesters, stalled datapath");
    dpStall = 1'b1;
    base = grantsSeen;
    applyStimulus(4'b1111, 8);
    @(negedge clk);
    #1;
    checkOutput("stall_issues", grantsSeen - base, DEPTH);
    dpStall = 1'b0;
    applyStimulus(4'b1111, 12);
    applyStimulus(4'b0000, 12);

    $display("[TB] unexpected result with nothing outstanding");
    @(negedge clk);
    injectData = 32'h1234;
    injectReqCnt++;
    applyStimulus(4'b0000, 6);
    @(negedge clk);
    #1;
    checkOutput("err_sticky", errUnexp, 1);

    $display("[TB] reset with three operations outstanding");
    dpStall = 1'b1;
    base = grantsSeen;
    applyStimulus(4'b0001, 3);
    applyStimulus(4'b0000, 2);
    checkOutput("pre_reset_outstanding", grantsSeen - base, 3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkResetOutputs("midrst");
    @(posedge clk);
    #1;
    reset   = 1'b0;
    dpStall = 1'b0;
    applyStimulus(4'b0000, 8);
    checkOutput("stale_err", errUnexp, 1);
    applyStimulus(4'b1010, 1);
    @(negedge clk);
    #1;
    checkOutput("post_rst_first", lastXfer, 4'b0010);
    applyStimulus(4'b1010, 8);
    applyStimulus(4'b0000, 8);

`ifdef DADD_ARB_STATS_EN
    $display("[TB] grant counter saturation");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    dpLat = 1;
    applyStimulus(4'b0010, 70000);
    applyStimulus(4'b0000, 8);
    @(negedge clk);
    checkOutput("gcnt1", grantCnt[1], 16'hFFFF);
    checkOutput("gcnt0", grantCnt[0], 0);
    checkOutput("gcnt2", grantCnt[2], 0);
    checkOutput("gcnt3", grantCnt[3], 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/dadd_arb.md
DADD_ARB -- requirements
Module: dadd_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one dadd datapath (2..8).
REQ-002 Parameter OSTD_DEPTH, default 4, maximum issued-but-unanswered dadd operations (power of 2, 2..16).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_addr  input  NUM_REQ x 32  per-requester operand address.
REQ-007 req_data  input  NUM_REQ x 32  per-requester operand data.
REQ-008 req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i] and req_ready[i].
REQ-009 dadd_in_en  output  1  issue strobe to the dadd datapath.
REQ-010 dadd_in_addr  output  32  issued address.
REQ-011 dadd_in  output  32  issued data.
REQ-012 dadd_out_en  input  1  result strobe from the datapath.
REQ-013 dadd_out_addr  input  32  result address.
REQ-014 dadd_out  input  32  result data.
REQ-015 rsp_valid  output  NUM_REQ  one-hot result strobe to the owning requester.
REQ-016 rsp_addr  output  32  result address, shared by all requesters.
REQ-017 rsp_data  output  32  result data, shared by all requesters.
REQ-018 err_unexp_rsp  output  1  sticky flag: result arrived with nothing outstanding.

Function
REQ-019 The datapath returns exactly one dadd_out_en per dadd_in_en, in issue order, at any latency >= 1 cycle.
REQ-020 Arbitration is round-robin: search starts at the requester after the last granted one; after reset it starts at requester 0.
REQ-021 req_ready is combinational from req_valid, the round-robin pointer and the outstanding count; at most one bit is high per cycle.
REQ-022 No grant is given while the outstanding count equals OSTD_DEPTH, even if dadd_out_en is high in the same cycle.
REQ-023 Issue latency is 1 cycle: a transfer in cycle N drives dadd_in_en=1, dadd_in_addr, dadd_in (registered) in cycle N+1; dadd_in_en=0 otherwise; addr/data hold their last value.
REQ-024 On each transfer the granted requester index is pushed into an ordered owner queue of depth OSTD_DEPTH.
REQ-025 On dadd_out_en with the queue non-empty, the head index is popped; in the next cycle rsp_valid[head]=1 and rsp_addr/rsp_data carry dadd_out_addr/dadd_out.
REQ-026 Push and pop in the same cycle leave the count unchanged; the queue pointers wrap modulo OSTD_DEPTH.
REQ-027 On dadd_out_en with the queue empty, the result is dropped, rsp_valid stays 0 and err_unexp_rsp is set until reset.
REQ-028 A requester holds req_valid, req_addr and req_data stable until its transfer; withdrawing req_valid before the grant is permitted and loses nothing.
REQ-029 Sustained throughput is one issue per cycle while the queue is not full.

Reset
REQ-030 Reset clears req_ready-driving state, dadd_in_en=0, dadd_in_addr=0, dadd_in=0, rsp_valid=0, rsp_addr=0, rsp_data=0, err_unexp_rsp=0, empties the queue and sets the round-robin pointer to requester 0.
REQ-031 Reset asserted mid-operation discards all outstanding owners; results returned after reset release count as unexpected.

Configuration
REQ-032 With DADD_ARB_STATS_EN defined, output grant_cnt (NUM_REQ x 16) holds a per-requester count of transfers that saturates at 0xFFFF and is cleared by reset.
REQ-033 Without DADD_ARB_STATS_EN, the grant_cnt port and its counters do not exist.

Structure
REQ-034 Package dadd_arb_pkg holds the default NUM_REQ and OSTD_DEPTH constants, the 32-bit address and data typedefs, and the requester-index typedef.
REQ-035 The owner queue is sub-module dadd_arb_own_fifo, which provides push, pop, empty, full and the head index.

Verification
REQ-036 Requesters 0 and 2 valid continuously, datapath latency 3 -> grants alternate 0,2,0,2; each rsp_valid is one-hot to the correct owner, in issue order.
REQ-037 All 4 requesters valid, datapath stalls results -> exactly OSTD_DEPTH=4 issues, then req_ready=0 until the first dadd_out_en, then one more grant.
REQ-038 Queue full, dadd_out_en in cycle N -> no grant in N; grant in N+1; rsp_valid asserted in N+1.
REQ-039 dadd_out_en=1 with nothing outstanding, dadd_out=0x1234 -> rsp_valid stays 0, err_unexp_rsp=1 and held until reset.
REQ-040 Reset asserted with 3 operations outstanding -> all outputs 0 and queue empty; pointer restarts at requester 0 on the first post-reset grant.
REQ-041 With DADD_ARB_STATS_EN: 70000 transfers from requester 1 -> grant_cnt[1]=0xFFFF and the other counters are 0.
